// File: rtl/display_rotator.sv
// display_rotator: rotates NUM_CH packed BCD channels onto one DIGITS-wide 7-seg feed.
// Each channel is shown for DWELL_CYCLES clocks. Disabled channels are skipped.
// hold freezes the dwell counter. next_pulse forces an advance. A per-channel mask
// saturates invalid BCD to all nines. Outputs are registered and lag ch_index by one cycle.
// Optional feature: define ROTATOR_BLANK_EN to insert a BLANK_CYCLES blank gap after
// every advance (SHOW -> BLANK -> SHOW).
module display_rotator #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DWELL_CYCLES = 200_000_000,
  parameter int unsigned CNT_W        = 28,
  parameter int unsigned BLANK_CYCLES = 10_000_000
) (
  input  logic                         clk100Mhz,
  input  logic                         rst_n,
  input  logic [NUM_CH*4*DIGITS-1:0]   ch_bcd,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_dp,
  input  logic [NUM_CH-1:0]            ch_sat,
  input  logic                         hold,
  input  logic                         next_pulse,
  output logic [4*DIGITS-1:0]          display_bcd,
  output logic                         dp,
  output logic [$clog2(NUM_CH)-1:0]    ch_index,
  output logic                         ch_valid
);

  localparam int unsigned IdxW  = $clog2(NUM_CH);
  localparam int unsigned CandW = IdxW + 1;
  localparam int unsigned DW    = 4 * DIGITS;
  localparam logic [CandW-1:0] NumChW  = CandW'(NUM_CH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_chk_num_ch
    $error("display_rotator: NUM_CH must be in 2..8");
  end
  if (DWELL_CYCLES < 2) begin : g_chk_dwell
    $error("display_rotator: DWELL_CYCLES must be >= 2");
  end
  if (CNT_W < 32 && (DWELL_CYCLES >> CNT_W) != 0) begin : g_chk_cnt_w
    $error("display_rotator: CNT_W too narrow for DWELL_CYCLES");
  end
  if (BLANK_CYCLES < 1) begin : g_chk_blank
    $error("display_rotator: BLANK_CYCLES must be >= 1");
  end

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    disp_q, disp_d;
  logic             dp_q, dp_d;
  logic             valid_q, valid_d;

  logic             any_en, cur_en, expire, adv, found, bad_nib, in_blank;
  logic [IdxW-1:0]  nxt_idx;
  logic [CandW-1:0] cand;
  logic [DW-1:0]    cur_data;

  assign any_en   = |ch_enable;
  assign cur_en   = ch_enable[idx_q];
  assign cur_data = ch_bcd[idx_q*DW +: DW];
  assign expire   = !hold && (cnt_q == CntLast);
  // A disabled current channel forces an advance just like dwell expiry.
  assign adv      = any_en && (next_pulse || expire || !cur_en);

  // Next channel: first enabled index after the current one, wrapping around.
  always_comb begin
    nxt_idx = idx_q;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i < NUM_CH; i++) begin
      cand = {1'b0, idx_q} + CandW'(i);
      if (cand >= NumChW) begin
        cand = cand - NumChW;
      end
      if (!found && ch_enable[cand[IdxW-1:0]]) begin
        nxt_idx = cand[IdxW-1:0];
        found   = 1'b1;
      end
    end
  end

`ifdef ROTATOR_BLANK_EN
  localparam int unsigned BlkW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {StShow, StBlank} state_e;

  state_e          state_q, state_d;
  logic [BlkW-1:0] blk_q, blk_d;

  assign in_blank = (state_q == StBlank);

  // Show/blank sequencing; ch_index moves on entry to blank.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    blk_d   = blk_q;
    unique case (state_q)
      StShow: begin
        if (adv) begin
          idx_d   = nxt_idx;
          cnt_d   = '0;
          blk_d   = '0;
          state_d = StBlank;
        end else if (any_en && !hold) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StBlank: begin
        // hold does not stall the gap; a manual pulse cuts it short.
        if (next_pulse && any_en) begin
          idx_d   = nxt_idx;
          cnt_d   = '0;
          blk_d   = '0;
          state_d = StShow;
        end else if (blk_q == BlkLast) begin
          blk_d   = '0;
          state_d = StShow;
        end else begin
          blk_d = blk_q + BlkW'(1);
        end
      end
      default: state_d = StShow;
    endcase
  end

  // Blank state register.
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StShow;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end
`else
  assign in_blank = 1'b0;

  // Direct SHOW -> SHOW rotation.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (adv) begin
      idx_d = nxt_idx;
      cnt_d = '0;
    end else if (any_en && !hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
`endif

  // Output data for the channel selected this cycle, with saturation on invalid BCD.
  always_comb begin
    disp_d  = '0;
    dp_d    = 1'b0;
    valid_d = 1'b0;
    bad_nib = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (cur_data[4*d +: 4] > 4'd9) begin
        bad_nib = 1'b1;
      end
    end
    if (in_blank && any_en) begin
      disp_d = '1;
    end else if (cur_en) begin
      valid_d = 1'b1;
      dp_d    = ch_dp[idx_q];
      disp_d  = (ch_sat[idx_q] && bad_nib) ? {DIGITS{4'h9}} : cur_data;
    end
  end

  // Rotation state and registered outputs.
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      dp_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
    end
  end

  assign display_bcd = disp_q;
  assign dp          = dp_q;
  assign ch_index    = idx_q;
  assign ch_valid    = valid_q;

endmodule

// File: tb/tb_display_rotator.sv
// Self-checking bench for display_rotator (NUM_CH=4, DIGITS=4, DWELL=8, BLANK=3).
// Honors ROTATOR_BLANK_EN when defined.
module tb_display_rotator;

  localparam int NCH   = 4;
  localparam int DIG   = 4;
  localparam int DWELL = 8;
`ifdef ROTATOR_BLANK_EN
  localparam int BLK = 3;
`else
  localparam int BLK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] bcd = '0;
  logic [3:0]  en = 4'hF;
  logic [3:0]  dpv = '0;
  logic [3:0]  sat = '0;
  logic        hold = 1'b0;
  logic        nxt = 1'b0;
  logic [15:0] disp;
  logic        dp_o;
  logic [1:0]  idx;
  logic        valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: shown channel, cycles into dwell, blank cycles left.
  int m_cur = 0;
  int m_age = 0;
  int m_blank = 0;
  logic [15:0] e_disp;
  logic        e_dp;
  logic        e_valid;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic        dpv;
    logic [15:0] exp_disp;
    logic        exp_dp;
  } vec_t;
  vec_t tbl[7];

  display_rotator #(
    .NUM_CH      (NCH),
    .DIGITS      (DIG),
    .DWELL_CYCLES(DWELL),
    .CNT_W       (4),
    .BLANK_CYCLES(3)
  ) dut (
    .clk100Mhz  (clk),
    .rst_n      (rst_n),
    .ch_bcd     (bcd),
    .ch_enable  (en),
    .ch_dp      (dpv),
    .ch_sat     (sat),
    .hold       (hold),
    .next_pulse (nxt),
    .display_bcd(disp),
    .dp         (dp_o),
    .ch_index   (idx),
    .ch_valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_bad(input logic [15:0] d);
    for (int i = 0; i < DIG; i++) begin
      if (((d >> (4 * i)) & 16'hF) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int next_en(input int cur, input logic [3:0] e);
    for (int off = 1; off <= NCH; off++) begin
      int c;
      c = (cur + off) % NCH;
      if (e[c]) return c;
    end
    return cur;
  endfunction

  task automatic model_out();
    logic [15:0] d;
    d = bcd[m_cur*16 +: 16];
    e_disp = '0;
    e_dp = 1'b0;
    e_valid = 1'b0;
    if (en == 4'h0) begin
      e_disp = '0;
    end else if (m_blank > 0) begin
      e_disp = 16'hFFFF;
    end else if (en[m_cur]) begin
      e_valid = 1'b1;
      e_dp = dpv[m_cur];
      e_disp = (sat[m_cur] && has_bad(d)) ? 16'h9999 : d;
    end
  endtask

  task automatic model_update();
    if (m_blank > 0) begin
      if (nxt && en != 4'h0) begin
        m_cur = next_en(m_cur, en);
        m_blank = 0;
        m_age = 0;
      end else begin
        m_blank--;
      end
    end else if (en != 4'h0) begin
      if (nxt || (!hold && m_age == DWELL - 1) || !en[m_cur]) begin
        m_cur = next_en(m_cur, en);
        m_age = 0;
        m_blank = BLK;
      end else if (!hold) begin
        m_age++;
      end
    end
  endtask

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic step();
    model_out();
    model_update();
    @(posedge clk);
    #1;
    chk("display_bcd", 32'(disp), 32'(e_disp));
    chk("dp", 32'(dp_o), 32'(e_dp));
    chk("ch_index", 32'(idx), m_cur);
    chk("ch_valid", 32'(valid), 32'(e_valid));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_display_bcd", 32'(disp), 32'h0);
    chk("reset_dp", 32'(dp_o), 32'h0);
    chk("reset_ch_index", 32'(idx), 32'h0);
    chk("reset_ch_valid", 32'(valid), 32'h0);
    m_cur = 0;
    m_age = 0;
    m_blank = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int last;
    int base;
    int q[$];

    tbl[0] = '{16'h12A4, 1'b1, 1'b1, 16'h9999, 1'b1};
    tbl[1] = '{16'h12A4, 1'b0, 1'b0, 16'h12A4, 1'b0};
    tbl[2] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1};
    tbl[3] = '{16'h9999, 1'b1, 1'b0, 16'h9999, 1'b0};
    tbl[4] = '{16'hF000, 1'b1, 1'b0, 16'h9999, 1'b0};
    tbl[5] = '{16'h000A, 1'b0, 1'b1, 16'h000A, 1'b1};
    tbl[6] = '{16'h8765, 1'b1, 1'b1, 16'h8765, 1'b1};

    #2;
    do_reset();

    // 1: rotation, mid-run reset, then 0 -> 1 -> 2 -> 3 -> 0.
    bcd = 64'h4444_3333_2222_1111;
    repeat (13) step();
    do_reset();
    step();
    chk("post_reset_ch0_disp", 32'(disp), 32'h1111);
    chk("post_reset_ch0_valid", 32'(valid), 32'h1);
    repeat (DWELL - 1) step();
    chk("seq_ch1", 32'(idx), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      repeat (DWELL + BLK) step();
      chk("seq_next", 32'(idx), k % NCH);
    end

    // 2: only channels 1 and 3 enabled, then drop 3 mid-dwell.
    en = 4'b1010;
    last = int'(idx);
    for (int i = 0; i < 60; i++) begin
      step();
      if (int'(idx) != last) begin
        q.push_back(int'(idx));
        last = int'(idx);
      end
    end
    chk("alt_changes", 32'(q.size() >= 4), 32'h1);
    for (int i = 0; i < q.size(); i++) begin
      chk("alt_member", 32'(q[i] == 1 || q[i] == 3), 32'h1);
      if (i > 0) chk("alt_toggle", 32'(q[i] != q[i-1]), 32'h1);
    end
    n = 0;
    while (idx !== 2'd3 && n < 30) begin
      step();
      n++;
    end
    chk("reach_ch3", 32'(idx), 32'd3);
    repeat (BLK + 3) step();
    en = 4'b0010;
    step();
    chk("disable_cur_adv", 32'(idx), 32'd1);
    repeat (20) step();
    chk("single_en_stay", 32'(idx), 32'd1);

    // 3: table of data/saturation/dp vectors on channel 2.
    en = 4'hF;
    hold = 1'b1;
    n = 0;
    while (idx !== 2'd2 && n < 10) begin
      nxt = 1'b1;
      step();
      nxt = 1'b0;
      n++;
    end
    repeat (BLK + 1) step();
    chk("tbl_at_ch2", 32'(idx), 32'd2);
    for (int i = 0; i < 7; i++) begin
      bcd[47:32] = tbl[i].data;
      sat[2] = tbl[i].sat;
      dpv[2] = tbl[i].dpv;
      step();
      chk("tbl_disp", 32'(disp), 32'(tbl[i].exp_disp));
      chk("tbl_dp", 32'(dp_o), 32'(tbl[i].exp_dp));
    end

    // 4: hold freezes; manual pulse under hold; pulse on the expiry cycle.
    base = int'(idx);
    repeat (30) step();
    chk("hold_no_change", 32'(idx), base);
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    chk("pulse_in_hold", 32'(idx), (base + 1) % NCH);
    hold = 1'b0;
    repeat (BLK + DWELL - 1) step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    chk("pulse_on_expiry", 32'(idx), (base + 2) % NCH);
    repeat (DWELL - 1 + BLK) step();
    chk("expiry_cnt_cleared", 32'(idx), (base + 2) % NCH);
    step();
    chk("expiry_next_adv", 32'(idx), (base + 3) % NCH);

    // 5: nothing enabled, then channel 2 alone.
    sat = '0;
    bcd = 64'h4444_5678_2222_1111;
    en = 4'h0;
    repeat (2) step();
    chk("none_valid", 32'(valid), 32'h0);
    chk("none_disp", 32'(disp), 32'h0);
    chk("none_dp", 32'(dp_o), 32'h0);
    en = 4'b0100;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("reen_valid", 32'(valid), 32'h1);
    chk("reen_idx", 32'(idx), 32'd2);
    chk("reen_disp", 32'(disp), 32'h5678);

`ifdef ROTATOR_BLANK_EN
    // 6: blank gap after a manual advance.
    en = 4'hF;
    hold = 1'b1;
    repeat (BLK + 2) step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      step();
      chk("blank_disp", 32'(disp), 32'hFFFF);
      chk("blank_dp", 32'(dp_o), 32'h0);
      chk("blank_valid", 32'(valid), 32'h0);
    end
    step();
    chk("blank_end_valid", 32'(valid), 32'h1);
    hold = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        en = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        bcd = {$urandom, $urandom};
        sat = 4'($urandom);
        dpv = 4'($urandom);
      end
      hold = ($urandom_range(0, 3) == 0);
      nxt = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
